// File: rtl/stage_mem_bus_if.sv
// Request/grant/response data bus between the MEM stage and the memory system.
// Signal names keep the stage-side view so existing netlists map one-to-one.
interface stage_mem_bus_if #(
    parameter int ADDR_W = 32
);
    logic              o_mem_req;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [3:0]        o_mem_bmask;
    logic              i_mem_gnt;
    logic              i_mem_rvalid;
    logic [31:0]       i_mem_rdata;

    modport master (
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
        input  i_mem_gnt, i_mem_rvalid, i_mem_rdata
    );

    modport slave (
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
        output i_mem_gnt, i_mem_rvalid, i_mem_rdata
    );
endinterface

// File: rtl/stage_mem_bus.sv
// MEM stage driving loads/stores onto a variable-latency request/grant bus,
// stalling the pipeline until each access resolves or times out.
module stage_mem_bus #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ctrl_valid,
    input  logic              i_ctrl_bubble,
    input  logic              i_ctrl_kill,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_store_data,
    output logic              o_stall_req,
    output logic [31:0]       o_ld_data,
    output logic              o_ld_valid,
    output logic              o_misaligned,
    output logic              o_bus_err,
    stage_mem_bus_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_DATA,
        DRAIN
    } state_t;

    state_t            state, nxt_state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              cnt_clr, cnt_inc, latch_en;

    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [31:0]       lat_wdata;
    logic [3:0]        lat_bmask;
    logic [2:0]        lat_funct3;
    logic [1:0]        lat_off;

    logic              act, mis, go, timeout;
    logic [ADDR_W-1:0] live_addr;
    logic [31:0]       live_wdata;
    logic [3:0]        live_bmask;

    // funct3[1:0]: 00 byte, 01 half, 1x word (reserved encodings land here)
    function automatic logic [3:0] calc_bmask(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   calc_bmask = 4'b0001 << off;
            2'b01:   calc_bmask = 4'b0011 << off;
            default: calc_bmask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   calc_wdata = {4{d[7:0]}};
            2'b01:   calc_wdata = {2{d[15:0]}};
            default: calc_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic [31:0] lane;
        lane = rdata >> {off, 3'b000};
        case (f3[1:0])
            2'b00:   fmt_load = f3[2] ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'b01:   fmt_load = f3[2] ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: fmt_load = rdata;
        endcase
    endfunction

    always_comb begin
        act = i_ctrl_valid & ~i_ctrl_bubble & ~i_ctrl_kill & (i_mem_read | i_mem_write);
        case (i_funct3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = i_addr[0];
            default: mis = |i_addr[1:0];
        endcase
        go         = act & ~mis;
        live_addr  = {i_addr[ADDR_W-1:2], 2'b00};
        live_wdata = calc_wdata(i_funct3, i_store_data);
        live_bmask = calc_bmask(i_funct3, i_addr[1:0]);
        timeout    = (MAX_WAIT > 0) && (wait_cnt == CNT_W'(MAX_WAIT));
    end

    // Outputs are Mealy: the idle request and load data follow live inputs.
    always_comb begin
        nxt_state        = state;
        cnt_clr          = 1'b0;
        cnt_inc          = 1'b0;
        latch_en         = 1'b0;
        o_stall_req      = 1'b0;
        o_ld_data        = '0;
        o_ld_valid       = 1'b0;
        o_misaligned     = 1'b0;
        o_bus_err        = 1'b0;
        bus.o_mem_req    = 1'b0;
        bus.o_mem_we     = 1'b0;
        bus.o_mem_addr   = '0;
        bus.o_mem_wdata  = '0;
        bus.o_mem_bmask  = '0;
        if (i_reset) begin
            o_misaligned = act & mis;
            case (state)
                IDLE: begin
                    if (go) begin
                        bus.o_mem_req   = 1'b1;
                        bus.o_mem_we    = i_mem_write;
                        bus.o_mem_addr  = live_addr;
                        bus.o_mem_wdata = live_wdata;
                        bus.o_mem_bmask = live_bmask;
                        latch_en        = 1'b1;
                        if (!bus.i_mem_gnt) begin
                            o_stall_req = 1'b1;
                            nxt_state   = WAIT_GNT;
                        end else if (!i_mem_write) begin
                            o_stall_req = 1'b1;
                            nxt_state   = WAIT_DATA;
                            cnt_clr     = 1'b1;
                        end
                    end
                end
                WAIT_GNT: begin
                    if (i_ctrl_kill) begin
                        nxt_state = IDLE;
                    end else begin
                        bus.o_mem_req   = 1'b1;
                        bus.o_mem_we    = lat_we;
                        bus.o_mem_addr  = lat_addr;
                        bus.o_mem_wdata = lat_wdata;
                        bus.o_mem_bmask = lat_bmask;
                        if (!bus.i_mem_gnt) begin
                            o_stall_req = 1'b1;
                        end else if (lat_we) begin
                            nxt_state = IDLE;
                        end else begin
                            o_stall_req = 1'b1;
                            nxt_state   = WAIT_DATA;
                            cnt_clr     = 1'b1;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (bus.i_mem_rvalid) begin
                        o_ld_valid = 1'b1;
                        o_ld_data  = fmt_load(lat_funct3, lat_off, bus.i_mem_rdata);
                        nxt_state  = IDLE;
                    end else if (timeout) begin
                        o_bus_err  = 1'b1;
                        o_ld_valid = 1'b1;
                        nxt_state  = IDLE;
                    end else if (i_ctrl_kill) begin
                        nxt_state = DRAIN;
                        cnt_clr   = 1'b1;
                    end else begin
                        o_stall_req = 1'b1;
                        cnt_inc     = 1'b1;
                    end
                end
                DRAIN: begin
                    // A drain timeout reports the error but keeps any new access held.
                    o_stall_req = go;
                    if (bus.i_mem_rvalid) begin
                        nxt_state = IDLE;
                    end else if (timeout) begin
                        o_bus_err = 1'b1;
                        nxt_state = IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            lat_bmask  <= '0;
            lat_funct3 <= '0;
            lat_off    <= '0;
        end else begin
            state <= nxt_state;
            if (cnt_clr) begin
                wait_cnt <= '0;
            end else if (cnt_inc) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (latch_en) begin
                lat_addr   <= live_addr;
                lat_we     <= i_mem_write;
                lat_wdata  <= live_wdata;
                lat_bmask  <= live_bmask;
                lat_funct3 <= i_funct3;
                lat_off    <= i_addr[1:0];
            end
        end
    end

endmodule
